mux_rr_nto1: RTL and testbench

MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_rr_nto1_rr_arbiter.sv | 29 ++
 rtl/mux_rr_nto1.sv | 142 ++++++++++++++
 tb/tb_mux_rr_nto1.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin N-to-1 mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned CHANNELS_MIN = 2;
  localparam int unsigned CHANNELS_MAX = 8;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Channel index following idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mux_rr_nto1_rr_arbiter.sv
// Round-robin arbiter: first requesting channel at or above ptr, wrapping upward.
module rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     idx
);

  int unsigned c;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      c = (32'(ptr) + 32'(i)) % CHANNELS;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N-to-1 registered mux with fixed or round-robin channel selection.
// Optional packet lock on round-robin grants: MUX_RR_NTO1_LOCK_EN.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter  int unsigned SIZE     = 32,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [CHANNELS-1:0]      valid_i,
  output logic [CHANNELS-1:0]      ready_o,
  input  logic                     mode_i,
  input  logic [SELW-1:0]          select_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [SELW-1:0]          chan_o
`ifdef MUX_RR_NTO1_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]      last_i
`endif
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("mux_rr_nto1: CHANNELS out of range");
  end

  logic [SELW-1:0]     rr_ptr;
  logic [SELW-1:0]     arb_idx;
  logic [SELW-1:0]     sel_idx;
  logic [CHANNELS-1:0] arb_req;
  logic [CHANNELS-1:0] arb_grant;
  logic [CHANNELS-1:0] grant;
  logic                out_free;
  logic                xfer;
  logic                rr_xfer;
  logic                ptr_adv;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

`ifdef MUX_RR_NTO1_LOCK_EN
  lock_state_e     lock_state_q;
  lock_state_e     lock_state_d;
  logic [SELW-1:0] lock_chan_q;
  logic [SELW-1:0] lock_chan_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lock_state_q <= LOCK_IDLE;
      lock_chan_q  <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_chan_q  <= lock_chan_d;
    end
  end

  // A round-robin beat without last pins the grant to its channel.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_chan_d  = lock_chan_q;
    ptr_adv      = 1'b0;
    case (lock_state_q)
      LOCK_IDLE: begin
        if (rr_xfer) begin
          if (last_i[sel_idx]) begin
            ptr_adv = 1'b1;
          end else begin
            lock_state_d = LOCK_HELD;
            lock_chan_d  = sel_idx;
          end
        end
      end
      LOCK_HELD: begin
        if (rr_xfer && last_i[sel_idx]) begin
          lock_state_d = LOCK_IDLE;
          ptr_adv      = 1'b1;
        end
      end
      default: lock_state_d = LOCK_IDLE;
    endcase
  end

  assign arb_req = (lock_state_q == LOCK_HELD)
                 ? (valid_i & (CHANNELS'(1) << lock_chan_q)) : valid_i;
`else
  assign arb_req = valid_i;
  assign ptr_adv = rr_xfer;
`endif

  always_comb begin
    grant   = '0;
    sel_idx = '0;
    if (mode_i == MODE_FIXED) begin
      if (32'(select_i) < CHANNELS) begin
        if (valid_i[select_i]) begin
          grant[select_i] = 1'b1;
          sel_idx         = select_i;
        end
      end
    end else begin
      grant   = arb_grant;
      sel_idx = arb_idx;
    end
  end

  assign out_free = !valid_o || ready_i;
  assign ready_o  = (rst_i && out_free) ? grant : '0;
  assign xfer     = |ready_o;
  assign rr_xfer  = xfer && (mode_i == MODE_RR);

  // Output register: load on transfer, drain when downstream takes the beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= data_i[32'(sel_idx)*SIZE +: SIZE];
      chan_o  <= sel_idx;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr <= '0;
    end else if (ptr_adv) begin
      rr_ptr <= SELW'(wrap_inc(32'(sel_idx), CHANNELS));
    end
  end

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Self-checking bench for mux_rr_nto1 with a transaction-level reference model.
module tb_mux_rr_nto1;

  localparam int SIZE = 32;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic [CH*SIZE-1:0] data_i = '0;
  logic [CH-1:0]      valid_i = '0;
  logic [CH-1:0]      ready_o;
  logic               mode_i = 1'b0;
  logic [SELW-1:0]    select_i = '0;
  logic [SIZE-1:0]    data_o;
  logic               valid_o;
  logic               ready_i = 1'b0;
  logic [SELW-1:0]    chan_o;
  logic [CH-1:0]      last_i = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  int unsigned m_data;
  int          m_chan;
  int          m_ptr;
  bit          m_locked;
  int          m_lock;

  mux_rr_nto1 #(.SIZE(SIZE), .CHANNELS(CH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mode_i   (mode_i),
    .select_i (select_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .chan_o   (chan_o)
`ifdef MUX_RR_NTO1_LOCK_EN
    ,
    .last_i   (last_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic int model_grant();
    int c;
    if (mode_i == 1'b0) begin
      if (int'(select_i) < CH && valid_i[select_i]) return int'(select_i);
      return -1;
    end
`ifdef MUX_RR_NTO1_LOCK_EN
    if (m_locked) return valid_i[m_lock] ? m_lock : -1;
`endif
    for (int off = 0; off < CH; off++) begin
      c = (m_ptr + off) % CH;
      if (valid_i[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_locked = 0; m_lock = 0;
  endtask

  task automatic set_data(input int unsigned d0, input int unsigned d1,
                          input int unsigned d2, input int unsigned d3);
    data_i = {d3, d2, d1, d0};
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
  endtask

  // One clock: check ready_o against the model, clock, then check the output register.
  task automatic step(input string tag);
    int g;
    logic [CH-1:0] er;
    #3;
    g  = model_grant();
    er = (g >= 0 && (!m_valid || ready_i)) ? CH'(1) << g : '0;
    checks++;
    if (ready_o !== er) begin
      errors++;
      $display("FAIL %s ready_o got %b exp %b", tag, ready_o, er);
    end
    @(posedge clk_i);
    if (er != 0) begin
      m_valid = 1;
      m_data  = data_i[g*SIZE +: SIZE];
      m_chan  = g;
      if (mode_i) begin
`ifdef MUX_RR_NTO1_LOCK_EN
        if (last_i[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % CH;
        end else begin
          m_locked = 1;
          m_lock   = g;
        end
`else
        m_ptr = (g + 1) % CH;
`endif
      end
    end else if (ready_i) begin
      m_valid = 0;
    end
    #1;
    checks++;
    if (valid_o !== m_valid || data_o !== m_data || chan_o !== SELW'(m_chan)) begin
      errors++;
      $display("FAIL %s out got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
               tag, valid_o, data_o, chan_o, m_valid, m_data, m_chan);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; valid_i = '1; mode_i = 1'b1; ready_i = 1'b1;
    #2;
    checks++;
    if (valid_o !== 1'b0 || data_o !== '0 || chan_o !== '0 || ready_o !== '0) begin
      errors++;
      $display("FAIL reset got v=%b d=%h c=%0d r=%b exp all zero", valid_o, data_o, chan_o, ready_o);
    end
    apply_reset();
  endtask

  task automatic test_fixed();
    apply_reset();
    mode_i = 1'b0; select_i = 2'd2; valid_i = 4'b0110; ready_i = 1'b1;
    set_data(32'h11, 32'h22, 32'hA5, 32'h44);
    #3;
    checks++;
    if (ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_ready got %b exp 0100", ready_o);
    end
    #(-3 + 3);
    step("fixed");
    checks++;
    if (data_o !== 32'hA5 || chan_o !== 2'd2 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL fixed_out got d=%h c=%0d v=%b exp d=a5 c=2 v=1", data_o, chan_o, valid_o);
    end
    select_i = 2'd3; valid_i = 4'b0111;
    step("fixed_none");
  endtask

  task automatic test_rr_sequence();
    apply_reset();
    mode_i = 1'b1; valid_i = '1; ready_i = 1'b1;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 8; i++) begin
      step("rr_seq");
      checks++;
      if (chan_o !== SELW'(i % 4)) begin
        errors++;
        $display("FAIL rr_seq beat %0d chan_o got %0d exp %0d", i, chan_o, i % 4);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    mode_i = 1'b1; ready_i = 1'b1; valid_i = 4'b0100;
    set_data(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    step("wrap_prime");
    valid_i = 4'b0011;
    step("wrap0");
    checks++;
    if (chan_o !== 2'd0) begin
      errors++;
      $display("FAIL wrap_first chan_o got %0d exp 0", chan_o);
    end
    step("wrap1");
    checks++;
    if (chan_o !== 2'd1) begin
      errors++;
      $display("FAIL wrap_second chan_o got %0d exp 1", chan_o);
    end
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] hold_d;
    logic [SELW-1:0] hold_c;
    apply_reset();
    mode_i = 1'b1; ready_i = 1'b1; valid_i = '1;
    set_data(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    step("bp_load");
    hold_d = data_o; hold_c = chan_o;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      checks++;
      if (data_o !== hold_d || chan_o !== hold_c || valid_o !== 1'b1 || ready_o !== '0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got d=%h c=%0d v=%b r=%b exp d=%h c=%0d v=1 r=0",
                 i, data_o, chan_o, valid_o, ready_o, hold_d, hold_c);
      end
    end
    ready_i = 1'b1;
    step("bp_release");
    checks++;
    if (chan_o !== 2'd1 || data_o !== 32'hC1) begin
      errors++;
      $display("FAIL bp_release got c=%0d d=%h exp c=1 d=c1", chan_o, data_o);
    end
    valid_i = '0;
    step("bp_drain");
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain valid_o got %b exp 0", valid_o);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mode_i = 1'b1; ready_i = 1'b0; valid_i = '1;
    set_data(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    step("mid_a");
    step("mid_b");
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== '0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_mid got v=%b r=%b d=%h exp 0", valid_o, ready_o, data_o);
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1; ready_i = 1'b1;
    step("mid_after");
    checks++;
    if (chan_o !== 2'd0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_first got c=%0d v=%b exp c=0 v=1", chan_o, valid_o);
    end
  endtask

  task automatic test_lock();
`ifdef MUX_RR_NTO1_LOCK_EN
    int exp_c [4] = '{1, 1, 1, 2};
    apply_reset();
    mode_i = 1'b1; ready_i = 1'b1; valid_i = 4'b0110;
    set_data(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    for (int i = 0; i < 4; i++) begin
      last_i = (i == 2) ? 4'b0010 : 4'b0000;
      step("lock");
      checks++;
      if (chan_o !== SELW'(exp_c[i])) begin
        errors++;
        $display("FAIL lock beat %0d chan_o got %0d exp %0d", i, chan_o, exp_c[i]);
      end
    end
    last_i = '0;
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      mode_i   = ($urandom_range(0, 3) != 0);
      select_i = SELW'($urandom_range(0, 3));
      valid_i  = CH'($urandom);
      ready_i  = ($urandom_range(0, 3) != 0);
      last_i   = CH'($urandom);
      set_data($urandom, $urandom, $urandom, $urandom);
      step("random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_rr_sequence();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
